// File: rtl/bfu_inv_pkg.sv
// Shared FFT constants, the complex sample type and the fixed-point helpers
// used by both the forward and the inverse butterfly.
package fft_consts;

    localparam int DW        = 16;
    localparam int FRAC_BITS = 15;

    // Width of the widest intermediate: the sum of two full-precision products.
    localparam int WW = 2 * DW + 2;

    localparam logic signed [WW-1:0] SAT_MAX = WW'(2 ** (DW - 1) - 1);
    localparam logic signed [WW-1:0] SAT_MIN = WW'(-(2 ** (DW - 1)));

    typedef struct packed {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } complex_t;

    // Round half up, then divide by 2^sh (floor via arithmetic shift).
    function automatic logic signed [WW-1:0] round_shift(input logic signed [WW-1:0] x,
                                                         input int unsigned           sh);
        logic signed [WW-1:0] half;
        half = WW'(1) << (sh - 1);
        return (x + half) >>> sh;
    endfunction

    // Clamp a wide intermediate into the DW-bit component range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [WW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DW-1:0];
        if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

endpackage

// File: rtl/bfu_inv_if.sv
// Operand/result handshake bundle of the inverse butterfly.
interface bfu_inv_if;

    logic                 in_valid;
    logic                 in_ready;
    fft_consts::complex_t A_in;
    fft_consts::complex_t B_in;
    fft_consts::complex_t W_in;
    logic                 out_valid;
    logic                 out_ready;
    fft_consts::complex_t A_out;
    fft_consts::complex_t B_out;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, A_in, B_in, W_in, out_ready,
        input  in_ready, out_valid, A_out, B_out
    );

    // The butterfly itself.
    modport slave (
        input  in_valid, A_in, B_in, W_in, out_ready,
        output in_ready, out_valid, A_out, B_out
    );

endinterface

// File: rtl/pipe_stage_ctl.sv
// Valid/ready bookkeeping for one pipeline stage: holds the stage valid bit
// and tells the stage's data registers when to capture.
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst,
    input  logic up_valid_i,
    input  logic dn_ready_i,
    output logic valid_o,
    output logic ready_o,
    output logic load_o
);

    logic v_q;
    logic v_d;

    // An empty stage can always take something, so bubbles collapse.
    assign ready_o = ~v_q | dn_ready_i;
    // NOTE: data registers only capture real operands; a loaded bubble leaves
    // them untouched because nothing downstream looks at them while v_q=0.
    assign load_o  = ready_o & up_valid_i;
    assign valid_o = v_q;

    // Next valid: refill from upstream when ready, otherwise hold.
    always_comb begin
        v_d = v_q;
        if (ready_o) v_d = up_valid_i;
    end

    // Stage valid register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking so every stage samples its neighbour's old state.
        if (!rst) v_q <= 1'b0;
        else      v_q <= v_d;
    end

endmodule

// File: rtl/bfu_inv.sv
// Inverse (Gentleman-Sande) radix-2 butterfly, 3-stage valid/ready pipeline:
//   A' = (A+B)/2,  B' = (A-B)*conj(W)/2  on Q1.15 complex samples.
module bfu_inv
    import fft_consts::*;
#(
    parameter int DW        = fft_consts::DW,
    parameter int FRAC_BITS = fft_consts::FRAC_BITS
) (
    input logic      clk,
    input logic      rst,
    bfu_inv_if.slave bus
);

    localparam int PW = 2 * DW + 1;  // one product
    localparam int XW = 2 * DW + 2;  // sum of two products

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;
    logic ld1, ld2, ld3;

    pipe_stage_ctl u_ctl_s1 (.clk, .rst, .up_valid_i(bus.in_valid), .dn_ready_i(rdy2),
                             .valid_o(v1), .ready_o(rdy1), .load_o(ld1));
    pipe_stage_ctl u_ctl_s2 (.clk, .rst, .up_valid_i(v1), .dn_ready_i(rdy3),
                             .valid_o(v2), .ready_o(rdy2), .load_o(ld2));
    pipe_stage_ctl u_ctl_s3 (.clk, .rst, .up_valid_i(v2), .dn_ready_i(bus.out_ready),
                             .valid_o(v3), .ready_o(rdy3), .load_o(ld3));

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3;

    // ---------------- S1: sum / difference at full precision ----------------
    logic signed [DW:0] s1_r_d, s1_i_d, d1_r_d, d1_i_d;
    logic signed [DW:0] s1_r_q, s1_i_q, d1_r_q, d1_i_q;
    complex_t           w1_q;

    // Sign-extend before adding so the carry bit is kept.
    always_comb begin
        s1_r_d = (DW + 1)'(bus.A_in.r) + (DW + 1)'(bus.B_in.r);
        s1_i_d = (DW + 1)'(bus.A_in.i) + (DW + 1)'(bus.B_in.i);
        d1_r_d = (DW + 1)'(bus.A_in.r) - (DW + 1)'(bus.B_in.r);
        d1_i_d = (DW + 1)'(bus.A_in.i) - (DW + 1)'(bus.B_in.i);
    end

    // Stage 1 registers: S, D and the twiddle travelling alongside.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: datapath registers are cleared too, so outputs read (0,0) in reset.
        if (!rst) begin
            s1_r_q <= '0;
            s1_i_q <= '0;
            d1_r_q <= '0;
            d1_i_q <= '0;
            w1_q   <= '0;
        end else if (ld1) begin
            s1_r_q <= s1_r_d;
            s1_i_q <= s1_i_d;
            d1_r_q <= d1_r_d;
            d1_i_q <= d1_i_d;
            w1_q   <= bus.W_in;
        end
    end

    // ---------------- S2: the four partial products ----------------
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
    logic signed [DW:0]   s2_r_q, s2_i_q;

    // Products of D with the raw twiddle; the conjugate is folded into S3 signs.
    always_comb begin
        p_rr_d = PW'(d1_r_q) * PW'(w1_q.r);
        p_ii_d = PW'(d1_i_q) * PW'(w1_q.i);
        p_ir_d = PW'(d1_i_q) * PW'(w1_q.r);
        p_ri_d = PW'(d1_r_q) * PW'(w1_q.i);
    end

    // Stage 2 registers: products plus the delayed sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ir_q <= '0;
            p_ri_q <= '0;
            s2_r_q <= '0;
            s2_i_q <= '0;
        end else if (ld2) begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ir_q <= p_ir_d;
            p_ri_q <= p_ri_d;
            s2_r_q <= s1_r_q;
            s2_i_q <= s1_i_q;
        end
    end

    // ---------------- S3: combine, halve with rounding, saturate ----------------
    logic signed [XW-1:0] re_d, im_d;
    complex_t             a_d, b_d;
    complex_t             a_q, b_q;

    // (Dr + jDi)(Wr - jWi): re = DrWr + DiWi, im = DiWr - DrWi.
    always_comb begin
        re_d  = XW'(p_rr_q) + XW'(p_ii_q);
        im_d  = XW'(p_ir_q) - XW'(p_ri_q);
        b_d.r = sat_dw(round_shift(re_d, FRAC_BITS + 1));
        b_d.i = sat_dw(round_shift(im_d, FRAC_BITS + 1));
        a_d.r = sat_dw(round_shift(XW'(s2_r_q), 1));
        a_d.i = sat_dw(round_shift(XW'(s2_i_q), 1));
    end

    // Output registers; they hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ld3) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign bus.A_out = a_q;
    assign bus.B_out = b_q;

endmodule

// File: tb/tb_bfu_inv.sv
// Self-checking bench for bfu_inv: arithmetic model + ordered scoreboard,
// plus directed vectors with hand-computed results.
module tb_bfu_inv;
    import fft_consts::*;

    logic clk;
    logic rst;
    bfu_inv_if bif ();

    bfu_inv dut (.clk(clk), .rst(rst), .bus(bif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int ar;
        int ai;
        int br;
        int bi;
    } exp_t;

    exp_t     exp_q[$];
    int       n_out = 0;
    bit       stall_prev = 0;
    complex_t held_a, held_b;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic complex_t cx(input int r, input int i);
        complex_t c;
        c.r = 16'(r);
        c.i = 16'(i);
        return c;
    endfunction

    function automatic int sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // floor(x / 2^k) with round-half-up: floor((x + 2^(k-1)) / 2^k)
    function automatic longint rnd_div(input longint x, input int k);
        longint n, d;
        n = x + (64'sd1 <<< (k - 1));
        d = 64'sd1 <<< k;
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic exp_t model(input complex_t a, input complex_t b, input complex_t w);
        exp_t   e;
        longint ar, ai, br, bi, wr, wi, dr, di;
        ar = a.r; ai = a.i; br = b.r; bi = b.i; wr = w.r; wi = w.i;
        dr = ar - br;
        di = ai - bi;
        e.ar = sat16(rnd_div(ar + br, 1));
        e.ai = sat16(rnd_div(ai + bi, 1));
        // (D) * conj(W) = (dr + j di)(wr - j wi)
        e.br = sat16(rnd_div(dr * wr + di * wi, 16));
        e.bi = sat16(rnd_div(di * wr - dr * wi, 16));
        return e;
    endfunction

    // Scoreboard / compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", longint'(bif.out_valid), 1);
                check("stall_hold_a", longint'(bif.A_out), longint'(held_a));
                check("stall_hold_b", longint'(bif.B_out), longint'(held_b));
            end
            if (bif.out_valid) begin
                check("out_has_pending_set", longint'(exp_q.size() > 0), 1);
                if (bif.out_ready && exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_out++;
                    check("sb_a_re", bif.A_out.r, e.ar);
                    check("sb_a_im", bif.A_out.i, e.ai);
                    check("sb_b_re", bif.B_out.r, e.br);
                    check("sb_b_im", bif.B_out.i, e.bi);
                end
            end
            if (bif.in_valid && bif.in_ready)
                exp_q.push_back(model(bif.A_in, bif.B_in, bif.W_in));
            stall_prev = bif.out_valid && !bif.out_ready;
            held_a     = bif.A_out;
            held_b     = bif.B_out;
        end
    end

    // Present one operand set and hold it until accepted (bounded).
    task automatic send(input complex_t a, input complex_t b, input complex_t w);
        bit ok;
        ok = 0;
        bif.A_in = a;
        bif.B_in = b;
        bif.W_in = w;
        bif.in_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (bif.in_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("send_accepted", ok, 1);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    // Single set through an empty pipe: check latency and literal result.
    task automatic directed(input string name, input complex_t a, input complex_t b,
                            input complex_t w, input complex_t ea, input complex_t eb);
        int lat;
        send(a, b, w);
        lat = 1;
        @(negedge clk);
        while (!bif.out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_a_re"}, bif.A_out.r, ea.r);
        check({name, "_a_im"}, bif.A_out.i, ea.i);
        check({name, "_b_re"}, bif.B_out.r, eb.r);
        check({name, "_b_im"}, bif.B_out.i, eb.i);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (exp_q.size() > 0 || bif.out_valid); n++) @(negedge clk);
        check("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    complex_t bp_a[6], bp_b[6], bp_w[6];
    bit       iv[14], ov[14];

    initial begin
        exp_t e;
        int   acc, idx, out_base;

        // Model pinned against hand-computed values.
        e = model(cx(8192, 0), cx(8192, 0), cx(32767, 0));
        check("model_sum_a", e.ar, 8192);
        check("model_sum_b", e.br, 0);
        e = model(cx(8192, 0), cx(0, 0), cx(0, 32767));
        check("model_conj_a", e.ar, 4096);
        check("model_conj_b_im", e.bi, -4096);
        e = model(cx(-32768, -32768), cx(32767, 32767), cx(-32768, -32768));
        check("model_sat_a", e.ar, 0);
        check("model_sat_b_re", e.br, 32767);
        check("model_sat_b_im", e.bi, 0);

        // Reset state.
        rst = 1'b0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        bif.A_in = '0;
        bif.B_in = '0;
        bif.W_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_a_out", longint'(bif.A_out), 0);
        check("rst_b_out", longint'(bif.B_out), 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bif.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors.
        directed("sum", cx(8192, 0), cx(8192, 0), cx(32767, 0), cx(8192, 0), cx(0, 0));
        directed("conj", cx(8192, 0), cx(0, 0), cx(0, 32767), cx(4096, 0), cx(0, -4096));
        directed("sat", cx(-32768, -32768), cx(32767, 32767), cx(-32768, -32768),
                 cx(0, 0), cx(32767, 0));
        drain(10);

        // Backpressure: 6 sets, consumer stalled for the first 6 cycles.
        for (int k = 0; k < 6; k++) begin
            bp_a[k] = cx(1000 * k + 100, -500 * k);
            bp_b[k] = cx(300 * k, 200 - 50 * k);
            bp_w[k] = cx(20000 - 3000 * k, 5000 * k - 7000);
        end
        out_base = n_out;
        bif.out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bif.A_in = bp_a[idx];
            bif.B_in = bp_b[idx];
            bif.W_in = bp_w[idx];
            bif.in_valid = 1'b1;
            @(negedge clk);
            if (bif.in_ready) begin
                acc++;
                if (idx < 5) idx++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts_before_full", acc, 3);
        @(negedge clk);
        check("bp_in_ready_low", bif.in_ready, 0);
        check("bp_out_valid_full", bif.out_valid, 1);
        @(posedge clk);
        #1;
        bif.out_ready = 1'b1;
        while (idx < 6) begin
            send(bp_a[idx], bp_b[idx], bp_w[idx]);
            idx++;
        end
        drain(20);
        check("bp_result_count", n_out - out_base, 6);

        // Bubbles: in_valid alternates 1/0, consumer always ready.
        for (int c = 0; c < 14; c++) begin
            bit pv;
            pv = (c < 8) && (c % 2 == 0);
            bif.in_valid = pv;
            bif.A_in = cx(c * 700 - 2000, 1234 - c * 300);
            bif.B_in = cx(-c * 450, c * 111);
            bif.W_in = cx(23170, -23170 + c * 1000);
            iv[c] = pv;
            @(negedge clk);
            ov[c] = bif.out_valid;
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
        for (int c = 0; c < 14; c++)
            check($sformatf("bubble_out_valid_%0d", c), ov[c], (c >= 3) ? iv[c - 3] : 1'b0);
        drain(10);

        // Reset mid-stream with 3 sets in flight.
        bif.out_ready = 1'b0;
        send(cx(5000, 100), cx(-3000, 200), cx(30000, 4000));
        send(cx(-7000, 900), cx(1000, -200), cx(12000, -9000));
        send(cx(300, -300), cx(600, 600), cx(-15000, 15000));
        check("midrst_full_before", bif.out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", bif.out_valid, 0);
        check("midrst_a_out", longint'(bif.A_out), 0);
        check("midrst_b_out", longint'(bif.B_out), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bif.in_ready, 1);
        check("midrst_no_stale", bif.out_valid, 0);
        @(posedge clk);
        #1;
        directed("post_rst", cx(8192, 0), cx(0, 0), cx(0, 32767), cx(4096, 0), cx(0, -4096));
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
